// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage -- instruction-fetch stage of the zzcpu five-stage pipeline.
//
// Holds the PC, reads the program SRAM (Ram2) combinationally, predecodes the
// fetched word for branches, predicts them with a 2-bit-counter BHT, and
// registers instruction / EPC / PC+1 / prediction into the IF/ID boundary.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   hold_i            load-use stall: freeze PC and IF/ID
//   flush_if_i        replace IF/ID contents with NOP_INST
//   jr_i, jr_addr_i   JR redirect and its target
//   prewrong_i        branch mispredicted in ID; fix_addr_i is the correct PC
//   bht_upd_i         branch resolved in ID: update BHT entry of bht_upd_pc_i
//                     with outcome bht_upd_tk_i
//   Ram2*             program SRAM interface (read-only, data bus left high-Z)
//   inst_o, pc_o,     IF/ID instruction, its address, address+1 and the
//   pcplus1_o,        prediction made for it
//   pred_taken_o
//
// Handshake: there is no valid/ready pair here; a new IF/ID entry is loaded
// on every rising edge unless hold_i freezes it, and redirects/flushes load
// NOP_INST instead of the fetched word.
// -----------------------------------------------------------------------------
module if_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          BHT_IDX  = 4,
  parameter logic [15:0] NOP_INST = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold_i,
  input  logic        flush_if_i,
  input  logic        jr_i,
  input  logic [15:0] jr_addr_i,
  input  logic        prewrong_i,
  input  logic [15:0] fix_addr_i,
  input  logic        bht_upd_i,
  input  logic [15:0] bht_upd_pc_i,
  input  logic        bht_upd_tk_i,
  output logic [17:0] Ram2Addr,
  inout  wire  [15:0] Ram2Data,
  output logic        Ram2OE,
  output logic        Ram2WE,
  output logic        Ram2EN,
  output logic [15:0] inst_o,
  output logic [15:0] pc_o,
  output logic [15:0] pcplus1_o,
  output logic        pred_taken_o
);

  localparam int BHT_N = 1 << BHT_IDX;

  logic [15:0] r_pc;
  logic [1:0]  r_bht [BHT_N];

  logic [15:0]        w_inst;
  logic [4:0]         w_opcode;
  logic               w_is_b;
  logic               w_is_bz;
  logic [BHT_IDX-1:0] w_pred_idx;
  logic [BHT_IDX-1:0] w_upd_idx;
  logic [15:0]        w_imm;
  logic [15:0]        w_pc_plus1;
  logic [15:0]        w_target;
  logic               w_pred;
  logic               w_redirect;
  logic [15:0]        w_next_pc;
  logic               w_unused_upd_pc;

  // SRAM is only ever read: chip and output enabled, writes disabled.
  assign Ram2Data = 16'hzzzz;
  assign Ram2Addr = {2'b00, r_pc};
  assign Ram2OE   = 1'b0;
  assign Ram2WE   = 1'b1;
  assign Ram2EN   = 1'b0;

  assign w_inst   = Ram2Data;
  assign w_opcode = w_inst[15:11];
  assign w_is_b   = (w_opcode == 5'b00010);
  assign w_is_bz  = (w_opcode == 5'b00100) || (w_opcode == 5'b00101);

  assign w_pred_idx = r_pc[BHT_IDX-1:0];
  assign w_upd_idx  = bht_upd_pc_i[BHT_IDX-1:0];
  assign w_unused_upd_pc = &{1'b0, bht_upd_pc_i[15:BHT_IDX]};

  // B carries an 11-bit offset, BEQZ/BNEZ an 8-bit one.
  assign w_imm = w_is_b ? {{5{w_inst[10]}}, w_inst[10:0]}
                        : {{8{w_inst[7]}}, w_inst[7:0]};

  assign w_pc_plus1 = r_pc + 16'd1;
  assign w_target   = w_pc_plus1 + w_imm;

  // B is always taken; conditional branches follow the counter MSB. The BHT
  // is read before any same-edge update lands, so prediction sees old value.
  assign w_pred = w_is_b | (w_is_bz & r_bht[w_pred_idx][1]);

  assign w_redirect = prewrong_i | jr_i;

  always_comb begin
    w_next_pc = w_pc_plus1;
    if (prewrong_i)  w_next_pc = fix_addr_i;
    else if (jr_i)   w_next_pc = jr_addr_i;
    else if (hold_i) w_next_pc = r_pc;
    else if (w_pred) w_next_pc = w_target;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_pc <= RESET_PC;
    else      r_pc <= w_next_pc;
  end

  // IF/ID boundary. Flush beats hold; a killed slot still records the PC it
  // replaced so EPC/MFPC stay meaningful.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_o       <= NOP_INST;
      pc_o         <= 16'h0000;
      pcplus1_o    <= 16'h0000;
      pred_taken_o <= 1'b0;
    end else if (w_redirect || flush_if_i) begin
      inst_o       <= NOP_INST;
      pc_o         <= r_pc;
      pcplus1_o    <= w_pc_plus1;
      pred_taken_o <= 1'b0;
    end else if (!hold_i) begin
      inst_o       <= w_inst;
      pc_o         <= r_pc;
      pcplus1_o    <= w_pc_plus1;
      pred_taken_o <= w_pred;
    end
  end

  // Saturating 2-bit counters; updates proceed regardless of hold_i.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BHT_N; i++) r_bht[i] <= 2'b01;
    end else if (bht_upd_i) begin
      if (bht_upd_tk_i) begin
        if (r_bht[w_upd_idx] != 2'b11) r_bht[w_upd_idx] <= r_bht[w_upd_idx] + 2'b01;
      end else begin
        if (r_bht[w_upd_idx] != 2'b00) r_bht[w_upd_idx] <= r_bht[w_upd_idx] - 2'b01;
      end
    end
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage of the zzcpu five-stage pipeline. It sits directly upstream of the ID stage. It holds the PC and reads instructions from the program SRAM (Ram2) asynchronously. It predicts branches with a 2-bit-counter BHT and registers the result into the IF/ID boundary (instruction, EPC, PC+1, prediction bit) consumed by ID, ID/EX and the hazard unit.

Parameters:
RESET_PC  16'h0000  PC value loaded on reset
BHT_IDX   4         log2 of BHT entries; the index is pc[BHT_IDX-1:0]
NOP_INST  16'h0800  instruction word injected on flush or redirect

Ports:
clk            in     1   system clock, rising edge
rst            in     1   reset, asynchronous, active-low
hold_i         in     1   load-use stall: freeze PC and IF/ID
flush_if_i     in     1   replace the IF/ID contents with NOP_INST
jr_i           in     1   JR redirect request from the hazard unit
jr_addr_i      in     16  JR target
prewrong_i     in     1   branch mispredicted in ID
fix_addr_i     in     16  correct next PC after a mispredict
bht_upd_i      in     1   branch resolved in ID; update the BHT
bht_upd_pc_i   in     16  PC of the resolved branch
bht_upd_tk_i   in     1   actual branch outcome
Ram2Addr       out    18  program SRAM address
Ram2Data       inout  16  program SRAM data
Ram2OE         out    1   active-low output enable
Ram2WE         out    1   active-low write enable
Ram2EN         out    1   active-low chip enable
inst_o         out    16  IF/ID instruction
pc_o           out    16  IF/ID EPC (address of inst_o)
pcplus1_o      out    16  IF/ID pc_o+1 (used by MFPC)
pred_taken_o   out    1   prediction made for inst_o

Behaviour:
- Reset is asynchronous and active-low. It acts immediately with no clock edge needed and can arrive mid-operation. Reset values:
  - pc = RESET_PC
  - inst_o = NOP_INST
  - pc_o = 0, pcplus1_o = 0, pred_taken_o = 0
  - all BHT entries = 2'b01 (weakly not-taken)
- SRAM is read-only from this block and combinational:
  - Ram2EN = 0, Ram2OE = 0, Ram2WE = 1 at all times, including during reset.
  - Ram2Data is driven to high-Z.
  - Ram2Addr = {2'b00, pc}.
- IF/ID update: on each rising edge the current Ram2Data, pc, pc+1 and the prediction are registered. Latency is one cycle: the word at address A appears on inst_o the cycle after pc = A.
- Predecode of Ram2Data[15:11]:
  - 00010 = B: sext(imm11), always predicted taken.
  - 00100 = BEQZ and 00101 = BNEZ: sext(imm8), taken iff BHT[pc idx][1] = 1.
  - Every other opcode is predicted not-taken.
- Predicted target = pc + 1 + sext(imm), computed mod 2^16. pc+1 also wraps: 16'hFFFF -> 16'h0000.
- Next-PC priority, highest first:
  1. prewrong_i -> fix_addr_i
  2. jr_i -> jr_addr_i
  3. hold_i -> pc unchanged
  4. predicted taken -> target
  5. otherwise pc+1
- Redirects override hold: when prewrong_i or jr_i is set, hold_i is ignored for the PC.
- IF/ID priority, highest first:
  1. prewrong_i, jr_i or flush_if_i -> inst_o = NOP_INST, pred_taken_o = 0; pc_o and pcplus1_o take the current pc and pc+1.
  2. hold_i -> all IF/ID outputs retain their value.
  3. otherwise load normally.
- Flush beats hold: if hold_i and flush_if_i arrive together, IF/ID gets the NOP and the PC holds.
- BHT update: on a rising edge with bht_upd_i = 1, entry[bht_upd_pc_i idx] saturates up if taken, down if not. It saturates at 2'b11 and 2'b00.
- BHT update is not blocked by hold_i.
- If a BHT update and a prediction use the same index in the same cycle, the prediction uses the pre-update value.
- No internal state machine beyond PC, IF/ID and the BHT. Every register is clocked only by clk and reset only by rst.

Test Plan:
1. Release rst with SRAM[k] = 16'h4000+k -> Ram2Addr reads 0,1,2,3. On the edge after pc = k, inst_o = 16'h4000+k, pc_o = k, pcplus1_o = k+1. Ram2OE = 0, Ram2WE = 1, Ram2EN = 0 throughout.
2. hold_i = 1 for 2 cycles while pc = 5 -> Ram2Addr stays 5 and inst_o/pc_o stay frozen at addr 4's values. Fetch then resumes at 5.
3. B at 0x0010 with imm = 11'h005 -> next Ram2Addr = 0x0016 and pred_taken_o = 1 alongside inst_o = the B word.
4. BEQZ at 0x0020 with imm = 8'hFE, BHT in reset state -> next fetch 0x0021. Then pulse bht_upd_i twice with taken for pc 0x0020 -> the next fetch of 0x0020 predicts 0x001F.
5. prewrong_i = 1 (fix_addr_i = 0x0100) together with jr_i = 1 (jr_addr_i = 0x0200) and hold_i = 1 -> pc = 0x0100 and inst_o = 16'h0800.
6. Assert rst low mid-run between clock edges -> pc, inst_o, pc_o and pred_taken_o reach their reset values immediately, and the BHT returns to 2'b01.
